// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access widths, FSM states, watchdog default.
package lsu_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte-enables/write data, load extract/extend, misalign detect.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic [31:0] store_data,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  load_addr_lo,
  input  logic [1:0]  load_width,
  input  logic        load_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = store_data;
    case (width)
      W_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      W_HALF: begin
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
      end
      // 2'b11 falls through as a word access
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  always_comb begin
    byte_sel  = rdata[7:0];
    half_sel  = load_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (load_addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    case (load_width)
      W_BYTE:  load_data = load_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      W_HALF:  load_data = load_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: latches an ALU-addressed load/store, runs it over a ready-handshake bus, stalls the core meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        ClkIn,
  input  logic        RstNIn,
  input  logic [31:0] AddrIn,
  input  logic [31:0] StoreDataIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  WidthIn,
  input  logic        UnsignedIn,
  output logic [31:0] LoadDataOut,
  output logic        StallOut,
  output logic        MisalignOut,
  output logic        BusErrOut,
  output logic        MemReqOut,
  output logic        MemWeOut,
  output logic [31:0] MemAddrOut,
  output logic [31:0] MemWdataOut,
  output logic [3:0]  MemBeOut,
  input  logic        MemReadyIn,
  input  logic [31:0] MemRdataIn
);

  lsu_state_e       state, state_next;
  logic [31:0]      addr_q, wdata_q, load_q;
  logic [3:0]       be_q;
  logic             we_q, uns_q, err_q;
  logic [1:0]       width_q;
  logic [CNT_W-1:0] wd_q;

  logic        misaligned, req_any, request, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_extract;

  lsu_lane_align u_align (
    .addr_lo       (AddrIn[1:0]),
    .width         (WidthIn),
    .store_data    (StoreDataIn),
    .misaligned    (misaligned),
    .be            (be_new),
    .wdata         (wdata_new),
    .load_addr_lo  (addr_q[1:0]),
    .load_width    (width_q),
    .load_unsigned (uns_q),
    .rdata         (MemRdataIn),
    .load_data     (load_extract)
  );

  assign req_any     = MemReadIn | MemWriteIn;
  assign request     = req_any & ~misaligned;
  assign timeout     = (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign LoadDataOut = load_q;

  always_comb begin
    state_next  = state;
    StallOut    = 1'b0;
    MisalignOut = 1'b0;
    BusErrOut   = 1'b0;
    MemReqOut   = 1'b0;
    MemWeOut    = 1'b0;
    MemAddrOut  = '0;
    MemWdataOut = '0;
    MemBeOut    = '0;
    case (state)
      S_IDLE: begin
        MisalignOut = req_any & misaligned;
        StallOut    = request;
        if (request) state_next = S_ACCESS;
      end
      S_ACCESS: begin
        StallOut    = 1'b1;
        MemReqOut   = 1'b1;
        MemWeOut    = we_q;
        MemAddrOut  = {addr_q[31:2], 2'b00};
        MemWdataOut = wdata_q;
        MemBeOut    = be_q;
        if (MemReadyIn || timeout) state_next = S_DONE;
      end
      S_DONE: begin
        BusErrOut  = err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ClkIn) begin
    if (!RstNIn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      width_q <= '0;
      wd_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (request) begin
          addr_q  <= AddrIn;
          we_q    <= MemWriteIn;
          be_q    <= MemWriteIn ? be_new : 4'b1111;
          wdata_q <= MemWriteIn ? wdata_new : '0;
          width_q <= WidthIn;
          uns_q   <= UnsignedIn;
          wd_q    <= '0;
          err_q   <= 1'b0;
        end
        S_ACCESS: begin
          if (MemReadyIn) begin
            load_q <= we_q ? '0 : load_extract;
          end else if (timeout) begin
            load_q <= '0;
            err_q  <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
